// File: rtl/mux_seven_segment_display_if.sv
// Bus between the keypad/control logic (master) and the multiplexed
// seven-segment driver (slave).
// The master drives the hex values and the load strobe.
// The slave returns the pin-level segment and digit-enable signals.
interface mux_seven_segment_display_if #(
   parameter int NUM_DIGITS = 2
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [4*NUM_DIGITS-1:0] values;
   logic                    load;
   logic [6:0]              segments;
   logic [NUM_DIGITS-1:0]   digit_en_n;
   logic [IDX_W-1:0]        digit_idx;
   logic                    frame_start;

   modport master (
      output values, load,
      input  segments, digit_en_n, digit_idx, frame_start
   );

   modport slave (
      input  values, load,
      output segments, digit_en_n, digit_idx, frame_start
   );
endinterface

// File: rtl/mux_seven_segment_display.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Each digit is lit for REFRESH_DIV cycles. All digits are then dark for
// DEAD_CYCLES cycles before the next digit is lit, which suppresses ghosting.
// Values are double-buffered. The displayed (active) copy changes only on
// the edge where digit_idx wraps to 0, so a frame never mixes old and new data.
// Optional macro LEADING_ZERO_BLANK_EN: when defined, leading zero digits
// above digit 0 are blanked.
module mux_seven_segment_display #(
   parameter int NUM_DIGITS  = 2,
   parameter int REFRESH_DIV = 10000,
   parameter int DEAD_CYCLES = 1
) (
   input logic                        clk,
   input logic                        reset,   // asynchronous, active-low
   mux_seven_segment_display_if.slave bus
);
   localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_MAX  = (REFRESH_DIV > DEAD_CYCLES)
                             ? ((REFRESH_DIV > 2) ? REFRESH_DIV : 2)
                             : ((DEAD_CYCLES > 2) ? DEAD_CYCLES : 2);
   localparam int CNT_W    = $clog2(CNT_MAX);
   // The post-reset dead phase is at least one cycle, even with DEAD_CYCLES = 0.
   localparam int DEAD_LEN = (DEAD_CYCLES > 0) ? DEAD_CYCLES : 1;

   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {S_DEAD, S_ON} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
   logic [4*NUM_DIGITS-1:0] active_q, active_d;
   logic                    frame_start_q, frame_start_d;
   logic                    advance;

   logic [3:0]              nibble [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   blank;
   logic [3:0]              cur_nibble;
   logic                    cur_blank;

   genvar gi;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0:    hex_to_seg = 7'b0000001;
         4'h1:    hex_to_seg = 7'b1001111;
         4'h2:    hex_to_seg = 7'b0010010;
         4'h3:    hex_to_seg = 7'b0000110;
         4'h4:    hex_to_seg = 7'b1001100;
         4'h5:    hex_to_seg = 7'b0100100;
         4'h6:    hex_to_seg = 7'b0100000;
         4'h7:    hex_to_seg = 7'b0001111;
         4'h8:    hex_to_seg = 7'b0000000;
         4'h9:    hex_to_seg = 7'b0001100;
         4'hA:    hex_to_seg = 7'b0001000;
         4'hB:    hex_to_seg = 7'b1100000;
         4'hC:    hex_to_seg = 7'b0110001;
         4'hD:    hex_to_seg = 7'b1000010;
         4'hE:    hex_to_seg = 7'b0110000;
         default: hex_to_seg = 7'b0111000;
      endcase
   endfunction

   // State register. The asynchronous reset blanks the outputs at once,
   // because the outputs are decoded from this state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_DEAD;
         cnt_q         <= '0;
         idx_q         <= IDX_LAST;
         pending_q     <= '0;
         active_q      <= '0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         pending_q     <= pending_d;
         active_q      <= active_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Next-state logic covers the on/dead sequencing, the digit advance and
   // the swap of pending into active at the frame boundary.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + CNT_W'(1);
      idx_d         = idx_q;
      pending_d     = bus.load ? bus.values : pending_q;
      active_d      = active_q;
      frame_start_d = 1'b0;
      advance       = 1'b0;

      if (state_q == S_ON) begin
         if (cnt_q == ON_LAST) begin
            cnt_d = '0;
            if (DEAD_CYCLES == 0) begin
               advance = 1'b1;
            end else begin
               state_d = S_DEAD;
            end
         end
      end else begin
         if (cnt_q == DEAD_LAST) begin
            cnt_d   = '0;
            advance = 1'b1;
         end
      end

      if (advance) begin
         state_d = S_ON;
         if (idx_q == IDX_LAST) begin
            idx_d         = '0;
            // pending_d already includes a same-edge load, which gives the bypass.
            active_d      = pending_d;
            frame_start_d = 1'b1;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   // Per-digit nibble view of the active buffer and the digit enables.
   for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibble[gi]         = active_q[4*gi +: 4];
      assign bus.digit_en_n[gi] = !((state_q == S_ON) && (idx_q == IDX_W'(gi)));
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit above 0 is blank when it and every higher nibble are zero.
   for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_first
         assign blank[gi] = 1'b0;
      end else begin : g_upper
         assign blank[gi] = (active_q[4*NUM_DIGITS-1:4*gi] == '0);
      end
   end
`else
   assign blank = '0;
`endif

   // Select the nibble and blank flag of the current digit.
   always_comb begin
      cur_nibble = 4'h0;
      cur_blank  = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_nibble = nibble[k];
            cur_blank  = blank[k];
         end
      end
   end

   assign bus.segments    = ((state_q == S_ON) && !cur_blank) ? hex_to_seg(cur_nibble) : 7'h7F;
   assign bus.digit_idx   = idx_q;
   assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_mux_seven_segment_display.sv
// Bench for mux_seven_segment_display.
// Instance A has 2 digits, REFRESH_DIV=4 and DEAD_CYCLES=1 (frame = 10 cycles).
// Every cycle of instance A is checked against a frame-phase schedule
// through a scoreboard queue.
// Instance B has 4 digits, REFRESH_DIV=2 and DEAD_CYCLES=0. It covers
// leading-zero behaviour and the zero-dead-time path.
module tb_mux_seven_segment_display;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mux_seven_segment_display_if #(.NUM_DIGITS(2)) bus_a ();
   mux_seven_segment_display_if #(.NUM_DIGITS(4)) bus_b ();

   mux_seven_segment_display #(.NUM_DIGITS(2), .REFRESH_DIV(4), .DEAD_CYCLES(1)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
   );
   mux_seven_segment_display #(.NUM_DIGITS(4), .REFRESH_DIV(2), .DEAD_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
   );

   // Segment patterns, active-low {a..g}.
   localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111;
   localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0001100, SA = 7'b0001000, SB = 7'b1100000;
   localparam logic [6:0] SC = 7'b0110001, SD = 7'b1000010, SE = 7'b0110000, SF = 7'b0111000;
   localparam logic [6:0] OFF = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] ZLEAD = OFF;
`else
   localparam logic [6:0] ZLEAD = S0;
`endif

   typedef struct {
      logic [6:0] seg;
      logic [1:0] en;
      logic       idx;
      logic       fs;
   } exp_t;

   typedef struct {
      logic [7:0] val;
      logic [6:0] seg0;   // expected pattern for the low nibble (digit 0)
      logic [6:0] seg1;   // expected pattern for the high nibble (digit 1)
      logic       bypass; // load on the wrap edge itself
   } vec_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          tcur;
   logic [13:0] pend_segs, shown_segs;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock of instance A. The expected outputs for the coming cycle are
   // pushed when the stimulus is driven, then popped and compared on the
   // negedge after the edge.
   task automatic step(input logic [7:0] v, input logic ld, input logic [13:0] segs);
      exp_t e, got;
      int   tn, p;
      bus_a.values = v;
      bus_a.load   = ld;
      tn = tcur + 1;
      p  = tn % 10;
      if (ld) pend_segs = segs;
      if (p == 0) shown_segs = pend_segs;
      e.fs = (p == 0);
      if (p < 4) begin
         e.en = 2'b10; e.idx = 1'b0; e.seg = shown_segs[6:0];
      end else if (p == 4) begin
         e.en = 2'b11; e.idx = 1'b0; e.seg = OFF;
      end else if (p < 9) begin
         e.en = 2'b01; e.idx = 1'b1; e.seg = shown_segs[13:7];
      end else begin
         e.en = 2'b11; e.idx = 1'b1; e.seg = OFF;
      end
      sb.push_back(e);
      @(posedge clk);
      tcur = tn;
      @(negedge clk);
      bus_a.load = 1'b0;
      got = sb.pop_front();
      $display("A t=%0d ld=%b seg=%b en=%b idx=%0d fs=%b", tn, ld,
               bus_a.segments, bus_a.digit_en_n, bus_a.digit_idx, bus_a.frame_start);
      chk($sformatf("a_seg t=%0d", tn), 16'(bus_a.segments),    16'(got.seg));
      chk($sformatf("a_en t=%0d", tn),  16'(bus_a.digit_en_n),  16'(got.en));
      chk($sformatf("a_idx t=%0d", tn), 16'(bus_a.digit_idx),   16'(got.idx));
      chk($sformatf("a_fs t=%0d", tn),  16'(bus_a.frame_start), 16'(got.fs));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(bus_a.values, 1'b0, 14'h0);
   endtask

   // Idle until the next step produces frame phase p.
   task automatic advance_to(input int p);
      while (((tcur + 1) % 10) != p) step(bus_a.values, 1'b0, 14'h0);
   endtask

   task automatic wait_frame_b(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus_b.frame_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: got no frame_start expected one within 40 cycles", name);
      end
   endtask

   // Load v into instance B, then check all four digits of the frame that shows it.
   task automatic run_b(input logic [15:0] v, input logic [6:0] e0, input logic [6:0] e1,
                        input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0] exp_seg [4];
      logic [3:0] en_exp;
      exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
      bus_b.values = v;
      bus_b.load   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_b.load = 1'b0;
      wait_frame_b($sformatf("b_frame %h", v));
      for (int d = 0; d < 4; d++) begin
         if (d > 0) repeat (2) @(negedge clk);
         en_exp = ~(4'b0001 << d);
         $display("B v=%h digit=%0d seg=%b en=%b idx=%0d", v, d,
                  bus_b.segments, bus_b.digit_en_n, bus_b.digit_idx);
         chk($sformatf("b_seg %h d%0d", v, d), 16'(bus_b.segments),   16'(exp_seg[d]));
         chk($sformatf("b_en %h d%0d", v, d),  16'(bus_b.digit_en_n), 16'(en_exp));
         chk($sformatf("b_idx %h d%0d", v, d), 16'(bus_b.digit_idx),  16'(d));
      end
   endtask

   initial begin
      vec_t vecs[8];
      vecs[0] = '{8'h10, S0, S1, 1'b1};
      vecs[1] = '{8'h32, S2, S3, 1'b0};
      vecs[2] = '{8'h54, S4, S5, 1'b1};
      vecs[3] = '{8'h76, S6, S7, 1'b0};
      vecs[4] = '{8'h98, S8, S9, 1'b1};
      vecs[5] = '{8'hBA, SA, SB, 1'b0};
      vecs[6] = '{8'hDC, SC, SD, 1'b1};
      vecs[7] = '{8'hFE, SE, SF, 1'b0};

      // Reset held with a load pending: outputs are blank and idx is the last digit.
      reset        = 1'b0;
      bus_a.values = 8'h3A;
      bus_a.load   = 1'b1;
      bus_b.values = 16'h0;
      bus_b.load   = 1'b0;
      #23;
      chk("rst_seg", 16'(bus_a.segments),    16'(OFF));
      chk("rst_en",  16'(bus_a.digit_en_n),  16'h3);
      chk("rst_fs",  16'(bus_a.frame_start), 16'h0);
      chk("rst_idx", 16'(bus_a.digit_idx),   16'h1);

      // Release reset. Before the first edge there is one blank cycle.
      @(negedge clk);
      reset      = 1'b1;
      tcur       = -1;
      pend_segs  = {S0, S0};
      shown_segs = {S0, S0};
      #1;
      chk("blank_seg", 16'(bus_a.segments),    16'(OFF));
      chk("blank_en",  16'(bus_a.digit_en_n),  16'h3);
      chk("blank_fs",  16'(bus_a.frame_start), 16'h0);
      step(8'h3A, 1'b1, {S3, SA});
      idle(19);

      // Mid-frame load of 51 while digit 1 is on: takes effect only at the next frame.
      advance_to(6);
      step(8'h51, 1'b1, {S5, S1});
      idle(15);

      // Load exactly on the wrap edge: bypass into the frame that starts there.
      advance_to(0);
      step(8'hEF, 1'b1, {SE, SF});
      idle(9);

      // Decode table: each record is loaded either on the wrap edge or mid-frame.
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].bypass) advance_to(0);
         else advance_to(2);
         step(vecs[i].val, 1'b1, {vecs[i].seg1, vecs[i].seg0});
         advance_to(0);
         idle(10);
      end

      // Reset asserted mid S_ON blanks the outputs before any clock edge.
      advance_to(2);
      idle(1);
      #2 reset = 1'b0;
      #1;
      chk("async_seg", 16'(bus_a.segments),   16'(OFF));
      chk("async_en",  16'(bus_a.digit_en_n), 16'h3);
      chk("async_idx", 16'(bus_a.digit_idx),  16'h1);
      @(posedge clk);
      @(negedge clk);
      reset      = 1'b1;
      tcur       = -1;
      pend_segs  = {S0, S0};
      shown_segs = {S0, S0};
      idle(20);

      // Four-digit instance: leading-zero handling.
      run_b(16'h0007, S7, ZLEAD, ZLEAD, ZLEAD);
      run_b(16'h0407, S7, S0, S4, ZLEAD);
      run_b(16'h1000, S0, S0, S0, S1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
